// File: rtl/scalar_mul.sv
// Left-to-right double-and-add scalar multiplier driving an external point-add core.
// Optional build macro SCALAR_MUL_CONST_TIME_EN: issue an add on every bit, discarding results for zero bits.
module scalar_mul #(
    parameter int                    DATA_WIDTH = 256,
    parameter logic [DATA_WIDTH-1:0] p          = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] k,
    input  logic [DATA_WIDTH-1:0] Gx,
    input  logic [DATA_WIDTH-1:0] Gy,
    input  logic                  in_valid,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] Rx,
    output logic [DATA_WIDTH-1:0] Ry,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] add_Px,
    output logic [DATA_WIDTH-1:0] add_Py,
    output logic [DATA_WIDTH-1:0] add_Qx,
    output logic [DATA_WIDTH-1:0] add_Qy,
    output logic                  add_in_valid,
    input  logic [DATA_WIDTH-1:0] add_Rx,
    input  logic [DATA_WIDTH-1:0] add_Ry,
    input  logic                  add_out_valid
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] k_reg, gx_reg, gy_reg;
    logic [DATA_WIDTH-1:0] acc_x_reg, acc_y_reg;
    logic [DATA_WIDTH-1:0] rx_reg, ry_reg;
    logic [IW-1:0]         idx_reg;
    logic                  k_bit;

    assign k_bit = k_reg[idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (in_valid) state_next = LOAD;
            LOAD:     state_next = (k_reg == '0) ? DONE : DBL_REQ;
            DBL_REQ:  state_next = DBL_WAIT;
            DBL_WAIT: begin
                if (add_out_valid) begin
`ifdef SCALAR_MUL_CONST_TIME_EN
                    state_next = ADD_REQ;
`else
                    state_next = k_bit ? ADD_REQ : NEXT;
`endif
                end
            end
            ADD_REQ:  state_next = ADD_WAIT;
            ADD_WAIT: if (add_out_valid) state_next = NEXT;
            NEXT:     state_next = (idx_reg == '0) ? DONE : DBL_REQ;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            gx_reg    <= '0;
            gy_reg    <= '0;
            acc_x_reg <= '0;
            acc_y_reg <= '0;
            rx_reg    <= '0;
            ry_reg    <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Fold coordinates into [0,p) so the core never sees a non-canonical base point
                        k_reg     <= k;
                        gx_reg    <= (Gx >= p) ? Gx - p : Gx;
                        gy_reg    <= (Gy >= p) ? Gy - p : Gy;
                        acc_x_reg <= '0;
                        acc_y_reg <= '0;
                        idx_reg   <= IW'(DATA_WIDTH - 1);
                    end
                end
                DBL_WAIT: begin
                    if (add_out_valid) begin
                        acc_x_reg <= add_Rx;
                        acc_y_reg <= add_Ry;
                    end
                end
                ADD_WAIT: begin
`ifdef SCALAR_MUL_CONST_TIME_EN
                    if (add_out_valid && k_bit) begin
`else
                    if (add_out_valid) begin
`endif
                        acc_x_reg <= add_Rx;
                        acc_y_reg <= add_Ry;
                    end
                end
                NEXT: begin
                    if (idx_reg != '0) idx_reg <= idx_reg - 1'b1;
                end
                default: ;
            endcase
            // Result registers load on entry to DONE so they are valid alongside out_valid
            if (state_next == DONE) begin
                rx_reg <= acc_x_reg;
                ry_reg <= acc_y_reg;
            end
        end
    end

    always_comb begin
        busy         = (state_reg != IDLE);
        out_valid    = (state_reg == DONE);
        add_in_valid = (state_reg == DBL_REQ) || (state_reg == ADD_REQ);
        // The accumulator always rides on Q so the core resolves infinity inputs
        if ((state_reg == ADD_REQ) || (state_reg == ADD_WAIT)) begin
            add_Px = gx_reg;
            add_Py = gy_reg;
        end else begin
            add_Px = acc_x_reg;
            add_Py = acc_y_reg;
        end
        add_Qx = acc_x_reg;
        add_Qy = acc_y_reg;
        Rx     = rx_reg;
        Ry     = ry_reg;
    end

endmodule

// File: tb/tb_scalar_mul.sv
// Bench for scalar_mul: behavioural secp256k1 point-add core, directed jobs, result scoreboard.
module tb_scalar_mul;

    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam logic [255:0] NM1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364140;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] k = '0, Gx = '0, Gy = '0;
    logic         in_valid = 1'b0;
    logic         busy, out_valid, add_in_valid;
    logic [255:0] Rx, Ry, add_Px, add_Py, add_Qx, add_Qy;
    logic [255:0] add_Rx = '0, add_Ry = '0;
    logic         add_out_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int adds_total = 0;
    int adds_base = 0;
    int stab_errs = 0;
    int proto_errs = 0;
    int ov_count = 0;
    logic [511:0] exp_q[$];

    logic          outstanding = 1'b0;
    logic          inject_stray = 1'b0;
    int            cnt = 0;
    logic [1023:0] lat_ops;
    logic [511:0]  lat_res;

    scalar_mul dut (
        .clk(clk), .rst_n(rst_n), .k(k), .Gx(Gx), .Gy(Gy), .in_valid(in_valid),
        .busy(busy), .Rx(Rx), .Ry(Ry), .out_valid(out_valid),
        .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx), .add_Qy(add_Qy),
        .add_in_valid(add_in_valid), .add_Rx(add_Rx), .add_Ry(add_Ry),
        .add_out_valid(add_out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'b0, a} * {256'b0, b};
        return 256'(t % {256'b0, P});
    endfunction

    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
        return (a >= b) ? a - b : a + (P - b);
    endfunction

    function automatic logic [255:0] finv(input logic [255:0] a);
        logic [255:0] e, r, base;
        e = P - 256'd2;
        r = 256'd1;
        base = a;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = fmul(r, base);
            base = fmul(base, base);
        end
        return r;
    endfunction

    // Affine addition with (0,0) as the point at infinity
    function automatic logic [511:0] pt_add(input logic [255:0] px, input logic [255:0] py,
                                            input logic [255:0] qx, input logic [255:0] qy);
        logic [255:0] lam, x3, y3;
        if (px == '0 && py == '0) return {qx, qy};
        if (qx == '0 && qy == '0) return {px, py};
        if (px == qx) begin
            if (fadd(py, qy) == '0) return '0;
            lam = fmul(fmul(256'd3, fmul(px, px)), finv(fadd(py, py)));
        end else begin
            lam = fmul(fsub(qy, py), finv(fsub(qx, px)));
        end
        x3 = fsub(fsub(fmul(lam, lam), px), qx);
        y3 = fsub(fmul(lam, fsub(px, x3)), py);
        return {x3, y3};
    endfunction

    // Point-add core model with operand-stability and request-protocol monitoring
    always @(negedge clk) begin
        if (add_out_valid) begin
            add_out_valid = 1'b0;
            outstanding = 1'b0;
        end
        if (!rst_n) begin
            outstanding = 1'b0;
            add_out_valid = 1'b0;
        end else if (outstanding) begin
            if ({add_Px, add_Py, add_Qx, add_Qy} !== lat_ops) stab_errs++;
            if (add_in_valid !== 1'b0) proto_errs++;
            if (cnt == 0) begin
                add_out_valid = 1'b1;
                {add_Rx, add_Ry} = lat_res;
            end else begin
                cnt--;
            end
        end else if (add_in_valid === 1'b1) begin
            lat_ops = {add_Px, add_Py, add_Qx, add_Qy};
            lat_res = pt_add(add_Px, add_Py, add_Qx, add_Qy);
            outstanding = 1'b1;
            cnt = LAT - 1;
            adds_total++;
        end else if (inject_stray) begin
            add_out_valid = 1'b1;
            add_Rx = 256'h1234;
            add_Ry = 256'h5678;
        end
    end

    always @(negedge clk) if (out_valid === 1'b1) ov_count++;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [255:0] kk, input logic [255:0] gx, input logic [255:0] gy,
                             input bit track, input logic [511:0] expv);
        @(negedge clk);
        k = kk;
        Gx = gx;
        Gy = gy;
        in_valid = 1'b1;
        adds_base = adds_total;
        if (track) exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_adds, input int exp_lat);
        int cyc;
        logic [511:0] e;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " out_valid"}, {255'b0, out_valid}, 256'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (out_valid !== 1'b1) return;
        check({tag, " Rx"}, Rx, e[511:256]);
        check({tag, " Ry"}, Ry, e[255:0]);
        check({tag, " busy@done"}, {255'b0, busy}, 256'd1);
        check({tag, " add reqs"}, 256'(adds_total - adds_base), 256'(exp_adds));
        if (exp_lat > 0) check({tag, " latency"}, 256'(cyc), 256'(exp_lat));
        @(negedge clk);
        check({tag, " strobe width"}, {255'b0, out_valid}, 256'd0);
        check({tag, " busy after"}, {255'b0, busy}, 256'd0);
        check({tag, " Rx hold"}, Rx, e[511:256]);
    endtask

    int nz_adds_1, nz_adds_3, nz_adds_nm1;
    logic [255:0] neg_gy;
    int t;

    initial begin
`ifdef SCALAR_MUL_CONST_TIME_EN
        nz_adds_1 = 512;
        nz_adds_3 = 512;
        nz_adds_nm1 = 512;
`else
        nz_adds_1 = 257;
        nz_adds_3 = 258;
        nz_adds_nm1 = 256 + $countones(NM1);
`endif
        neg_gy = P - GY;

        repeat (3) @(negedge clk);
        check("reset busy", {255'b0, busy}, 256'd0);
        check("reset out_valid", {255'b0, out_valid}, 256'd0);
        check("reset add_in_valid", {255'b0, add_in_valid}, 256'd0);
        check("reset Rx", Rx, '0);
        check("reset Ry", Ry, '0);
        #2 rst_n = 1'b1;

        // Stray add-core strobe while idle must be ignored
        @(negedge clk);
        inject_stray = 1'b1;
        repeat (2) @(negedge clk);
        inject_stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray busy", {255'b0, busy}, 256'd0);
        check("stray out_valid", {255'b0, out_valid}, 256'd0);
        check("stray Rx", Rx, '0);

        start_job('0, GX, GY, 1'b1, '0);
        check("k0 busy@load", {255'b0, busy}, 256'd1);
        wait_result("k0", 0, 2);

        start_job(256'd1, GX, GY, 1'b1, {GX, GY});
        wait_result("k1", nz_adds_1, 0);

        start_job(256'd2, GX, GY, 1'b1, {G2X, G2Y});
        wait_result("k2", nz_adds_1, 0);

        // New request while busy must be dropped
        start_job(256'd2, GX, GY, 1'b1, {G2X, G2Y});
        repeat (20) @(negedge clk);
        k = 256'd5;
        Gx = 256'h77;
        Gy = 256'h99;
        in_valid = 1'b1;
        @(negedge clk);
        check("busy while pulsed", {255'b0, busy}, 256'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("busy after pulse", {255'b0, busy}, 256'd1);
        wait_result("busy job", nz_adds_1, 0);

        start_job(NM1, GX, GY, 1'b1, {GX, neg_gy});
        wait_result("k n-1", nz_adds_nm1, 0);

        // Abort a job during its first doubling wait
        start_job(256'd2, GX, GY, 1'b0, '0);
        t = 0;
        while (add_in_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort saw request", {255'b0, add_in_valid}, 256'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {255'b0, busy}, 256'd0);
        check("abort out_valid", {255'b0, out_valid}, 256'd0);
        check("abort add_in_valid", {255'b0, add_in_valid}, 256'd0);
        check("abort Rx", Rx, '0);
        check("abort Ry", Ry, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort no result", {255'b0, out_valid}, 256'd0);

        start_job(256'd3, GX, GY, 1'b1, {G3X, G3Y});
        wait_result("k3", nz_adds_3, 0);

        repeat (5) @(negedge clk);
        check("result strobe count", 256'(ov_count), 256'd6);
        check("operand stability errors", 256'(stab_errs), 256'd0);
        check("request protocol errors", 256'(proto_errs), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scalar_mul.md
SCALAR_MUL -- requirements
Module: scalar_mul

Interface
REQ-001 Parameter: DATA_WIDTH, default 256, width of scalar and coordinates.
REQ-002 Parameter: p, default secp256k1 prime FFFF...FFFE FFFFFC2F, field modulus; infinity is encoded as (0,0).
REQ-003 Reset is asynchronous, active-low, on port rst_n; the block has exactly one clock, clk. Ports, one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  async active-low reset
- k  input  DATA_WIDTH  scalar
- Gx, Gy  input  DATA_WIDTH each  base point, < p
- in_valid  input  1  start request
- busy  output  1  high from acceptance until the out_valid cycle inclusive
- Rx, Ry  output  DATA_WIDTH each  result k*G
- out_valid  output  1  one-cycle result strobe
- add_Px, add_Py, add_Qx, add_Qy  output  DATA_WIDTH each  operands to the point-add core
- add_in_valid  output  1  add-core start pulse
- add_Rx, add_Ry  input  DATA_WIDTH each  add-core result
- add_out_valid  input  1  add-core one-cycle done strobe

Function
REQ-004 Algorithm SHALL be left-to-right double-and-add over bits 255 down to 0: per bit, acc = acc+acc, then acc = G+acc if k[i]=1.
REQ-005 FSM states SHALL be IDLE, LOAD, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE.
REQ-006 IDLE: in_valid=1 latches k, Gx, Gy, sets acc=(0,0) and bit index i=255 -> LOAD; in_valid is ignored in every other state.
REQ-007 LOAD: k==0 -> DONE; otherwise -> DBL_REQ.
REQ-008 DBL_REQ: drive P=acc, Q=acc, pulse add_in_valid for exactly one cycle -> DBL_WAIT.
REQ-009 DBL_WAIT: on add_out_valid, capture acc={add_Rx,add_Ry}; k[i]=1 -> ADD_REQ, else -> NEXT.
REQ-010 ADD_REQ: drive P=G, Q=acc (accumulator always on Q so infinity is handled by the core), pulse add_in_valid -> ADD_WAIT.
REQ-011 ADD_WAIT: on add_out_valid, capture acc -> NEXT.
REQ-012 NEXT: i==0 -> DONE; else decrement i -> DBL_REQ.
REQ-013 DONE: Rx,Ry <= acc; out_valid=1 for exactly this cycle -> IDLE.
REQ-014 add_P*/add_Q* SHALL hold constant from the add_in_valid cycle until the add_out_valid cycle inclusive.
REQ-015 add_in_valid SHALL be asserted no earlier than the second cycle after an add_out_valid, and never while an add operation is outstanding.
REQ-016 add_out_valid arriving outside DBL_WAIT or ADD_WAIT SHALL be ignored.
REQ-017 Rx,Ry SHALL hold their value until the next DONE; k==0 yields (0,0).
REQ-018 Latency: k==0 -> out_valid 2 cycles after the in_valid edge; otherwise 3 + 256*(3+Ldbl) + popcount(k)*(2+Ladd) cycles approx, where L = add-core latency.

Reset
REQ-019 rst_n low SHALL force state IDLE, acc, Rx, Ry, latched k/G, i = 0, and out_valid, busy, add_in_valid = 0, immediately and at any point mid-operation; no result is produced for an aborted job.

Configuration
REQ-020 Macro SCALAR_MUL_CONST_TIME_EN defined: from DBL_WAIT, ADD_REQ is always entered; on k[i]=0 the add result is discarded (acc unchanged) in ADD_WAIT; this gives exactly 512 add requests per nonzero job.
REQ-021 Macro SCALAR_MUL_CONST_TIME_EN undefined: behaviour per REQ-009; 256 + popcount(k) add requests per nonzero job.

Verification
REQ-022 k=0 -> out_valid 2 cycles after in_valid, R=(0,0), zero add_in_valid pulses.
REQ-023 k=1, G = secp256k1 generator -> R=G; 257 add requests (512 with CONST_TIME).
REQ-024 k=2 -> Rx=C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Ry=1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A.
REQ-025 k=n-1 (n=secp256k1 order) -> R=(Gx, p-Gy).
REQ-026 in_valid pulsed while busy -> ignored, first result unchanged, busy stays high.
REQ-027 rst_n low during DBL_WAIT -> all outputs 0 next sample, no out_valid; a fresh k=3 job then yields 3G.
